// File: rtl/sonic_loopback_switch.sv
// Multi-lane, run-time switchable loopback between sonic tx/rx channels and the XCVR.
// A lane drives idle words on both of its outputs for a guard period while its mode changes.
module sonic_loopback_switch #(
    parameter int unsigned           NUM_LANES    = 2,
    parameter int unsigned           DATA_WIDTH   = 40,
    parameter int unsigned           GUARD_CYCLES = 4,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD    = '0,
    parameter logic [1:0]            RESET_MODE   = 2'd0
) (
    input  logic                            clk_in,
    input  logic                            reset,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] data_in_chan,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] data_in_xcvr,
    output logic [NUM_LANES*DATA_WIDTH-1:0] data_out_chan,
    output logic [NUM_LANES*DATA_WIDTH-1:0] data_out_xcvr,
    input  logic [NUM_LANES-1:0]            mode_wr,
    input  logic [2*NUM_LANES-1:0]          mode_in,
    output logic [2*NUM_LANES-1:0]          cur_mode,
    output logic [NUM_LANES-1:0]            switching,
    output logic [NUM_LANES-1:0]            mode_done,
    input  logic [NUM_LANES-1:0]            lb_count_clr,
    output logic [16*NUM_LANES-1:0]         lb_count
);

    typedef enum logic {ST_ACTIVE = 1'b0, ST_GUARD = 1'b1} state_t;
    typedef enum logic [1:0] {
        M_NORMAL  = 2'd0,
        M_NEAR_LB = 2'd1,
        M_FAR_LB  = 2'd2,
        M_ISOLATE = 2'd3
    } mode_t;

    localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES - 1);

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        state_t                r_state, w_state_nxt;
        mode_t                 r_cur_mode, w_cur_mode_nxt;
        mode_t                 r_target, w_target_nxt;
        logic [7:0]            r_gcnt, w_gcnt_nxt;
        logic                  r_mode_done, w_mode_done_nxt;
        logic [DATA_WIDTH-1:0] r_out_chan, w_out_chan_nxt;
        logic [DATA_WIDTH-1:0] r_out_xcvr, w_out_xcvr_nxt;
        logic [15:0]           r_lb_count, w_lb_count_nxt;
        logic [DATA_WIDTH-1:0] w_in_chan, w_in_xcvr;
        mode_t                 w_req;
        logic                  w_wr, w_clr;

        assign w_in_chan = data_in_chan[gi*DATA_WIDTH +: DATA_WIDTH];
        assign w_in_xcvr = data_in_xcvr[gi*DATA_WIDTH +: DATA_WIDTH];
        assign w_req     = mode_t'(mode_in[2*gi +: 2]);
        assign w_wr      = mode_wr[gi];
        assign w_clr     = lb_count_clr[gi];

        always_ff @(posedge clk_in) begin
            if (reset) begin
                r_state     <= ST_ACTIVE;
                r_cur_mode  <= mode_t'(RESET_MODE);
                r_target    <= mode_t'(RESET_MODE);
                r_gcnt      <= '0;
                r_mode_done <= 1'b0;
                r_out_chan  <= IDLE_WORD;
                r_out_xcvr  <= IDLE_WORD;
                r_lb_count  <= '0;
            end else begin
                r_state     <= w_state_nxt;
                r_cur_mode  <= w_cur_mode_nxt;
                r_target    <= w_target_nxt;
                r_gcnt      <= w_gcnt_nxt;
                r_mode_done <= w_mode_done_nxt;
                r_out_chan  <= w_out_chan_nxt;
                r_out_xcvr  <= w_out_xcvr_nxt;
                r_lb_count  <= w_lb_count_nxt;
            end
        end

        always_comb begin
            w_state_nxt     = r_state;
            w_cur_mode_nxt  = r_cur_mode;
            w_target_nxt    = r_target;
            w_gcnt_nxt      = r_gcnt;
            w_mode_done_nxt = 1'b0;
            w_out_chan_nxt  = IDLE_WORD;
            w_out_xcvr_nxt  = IDLE_WORD;
            w_lb_count_nxt  = r_lb_count;

            case (r_state)
                ST_ACTIVE: begin
                    // The word presented in the request cycle still follows the old mode.
                    case (r_cur_mode)
                        M_NORMAL: begin
                            w_out_chan_nxt = w_in_xcvr;
                            w_out_xcvr_nxt = w_in_chan;
                        end
                        M_NEAR_LB: w_out_chan_nxt = w_in_chan;
                        M_FAR_LB:  w_out_xcvr_nxt = w_in_xcvr;
                        default:   ;
                    endcase
                    if ((r_cur_mode == M_NEAR_LB || r_cur_mode == M_FAR_LB) && r_lb_count != '1) begin
                        w_lb_count_nxt = r_lb_count + 16'd1;
                    end
                    if (w_wr && w_req != r_cur_mode) begin
                        w_state_nxt  = ST_GUARD;
                        w_target_nxt = w_req;
                        w_gcnt_nxt   = GUARD_LOAD;
                    end
                end
                ST_GUARD: begin
                    if (w_wr) begin
                        w_target_nxt = w_req;
                        w_gcnt_nxt   = GUARD_LOAD;
                    end else if (r_gcnt == '0) begin
                        w_state_nxt     = ST_ACTIVE;
                        w_cur_mode_nxt  = r_target;
                        w_mode_done_nxt = 1'b1;
                    end else begin
                        w_gcnt_nxt = r_gcnt - 8'd1;
                    end
                end
                default: w_state_nxt = ST_ACTIVE;
            endcase

            if (w_clr) begin
                w_lb_count_nxt = '0;
            end
        end

        assign data_out_chan[gi*DATA_WIDTH +: DATA_WIDTH] = r_out_chan;
        assign data_out_xcvr[gi*DATA_WIDTH +: DATA_WIDTH] = r_out_xcvr;
        assign cur_mode[2*gi +: 2]                        = r_cur_mode;
        assign switching[gi]                              = (r_state == ST_GUARD);
        assign mode_done[gi]                              = r_mode_done;
        assign lb_count[16*gi +: 16]                      = r_lb_count;
    end

endmodule

// File: tb/tb_sonic_loopback_switch.sv
// Self-checking bench for sonic_loopback_switch: vector table, directed corner sequences
// and randomized traffic compared against a timestamp-based lane model.
module tb_sonic_loopback_switch;

    localparam int NL = 2;
    localparam int W  = 40;
    localparam int G  = 4;
    localparam logic [W-1:0] IDLE = '0;

    logic            clk_in = 1'b0;
    logic            reset;
    logic [NL*W-1:0] data_in_chan, data_in_xcvr, data_out_chan, data_out_xcvr;
    logic [NL-1:0]   mode_wr, switching, mode_done, lb_count_clr;
    logic [2*NL-1:0] mode_in, cur_mode;
    logic [16*NL-1:0] lb_count;

    always #5 clk_in = ~clk_in;

    sonic_loopback_switch #(
        .NUM_LANES   (NL),
        .DATA_WIDTH  (W),
        .GUARD_CYCLES(G),
        .IDLE_WORD   (IDLE),
        .RESET_MODE  (2'd0)
    ) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .data_in_chan (data_in_chan),
        .data_in_xcvr (data_in_xcvr),
        .data_out_chan(data_out_chan),
        .data_out_xcvr(data_out_xcvr),
        .mode_wr      (mode_wr),
        .mode_in      (mode_in),
        .cur_mode     (cur_mode),
        .switching    (switching),
        .mode_done    (mode_done),
        .lb_count_clr (lb_count_clr),
        .lb_count     (lb_count)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b1;

    // Lane model: a request accepted in cycle c keeps the lane switching until cycle c+G,
    // the new mode applies from cycle c+G+1.
    int       m_mode  [NL];
    int       m_target[NL];
    int       m_gend  [NL];
    bit       m_guard [NL];
    bit       m_done  [NL];
    int       m_lb    [NL];
    logic [W-1:0] m_oc[NL];
    logic [W-1:0] m_ox[NL];

    typedef struct {
        logic [1:0]   mode;
        logic [W-1:0] ic;
        logic [W-1:0] ix;
        logic [W-1:0] ec;
        logic [W-1:0] ex;
    } vec_t;
    vec_t tbl[6];

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [W-1:0] rand_word();
        return W'({$urandom(), $urandom()}) | W'(1);
    endfunction

    task automatic model_edge();
        for (int l = 0; l < NL; l++) begin
            logic [W-1:0] ic;
            logic [W-1:0] ix;
            int req;
            ic  = data_in_chan[l*W +: W];
            ix  = data_in_xcvr[l*W +: W];
            req = int'(mode_in[2*l +: 2]);
            if (reset) begin
                m_mode[l] = 0; m_target[l] = 0; m_guard[l] = 0; m_done[l] = 0;
                m_lb[l] = 0; m_oc[l] = IDLE; m_ox[l] = IDLE;
            end else begin
                m_done[l] = 0;
                if (m_guard[l]) begin
                    m_oc[l] = IDLE;
                    m_ox[l] = IDLE;
                end else begin
                    m_oc[l] = (m_mode[l] == 0) ? ix : (m_mode[l] == 1) ? ic : IDLE;
                    m_ox[l] = (m_mode[l] == 0) ? ic : (m_mode[l] == 2) ? ix : IDLE;
                end
                if (lb_count_clr[l]) m_lb[l] = 0;
                else if (!m_guard[l] && (m_mode[l] == 1 || m_mode[l] == 2) && m_lb[l] < 65535) m_lb[l]++;
                if (mode_wr[l] && (m_guard[l] || req != m_mode[l])) begin
                    m_guard[l] = 1; m_target[l] = req; m_gend[l] = cyc + G;
                end else if (m_guard[l] && cyc == m_gend[l]) begin
                    m_guard[l] = 0; m_mode[l] = m_target[l]; m_done[l] = 1;
                end
            end
        end
        cyc++;
    endtask

    task automatic compare_all();
        logic [NL*W-1:0]  ec, ex;
        logic [2*NL-1:0]  em;
        logic [NL-1:0]    es, ed;
        logic [16*NL-1:0] el;
        for (int l = 0; l < NL; l++) begin
            ec[l*W +: W]   = m_oc[l];
            ex[l*W +: W]   = m_ox[l];
            em[2*l +: 2]   = 2'(m_mode[l]);
            es[l]          = m_guard[l];
            ed[l]          = m_done[l];
            el[16*l +: 16] = 16'(m_lb[l]);
        end
        check("data_out_chan", 128'(data_out_chan), 128'(ec));
        check("data_out_xcvr", 128'(data_out_xcvr), 128'(ex));
        check("cur_mode", 128'(cur_mode), 128'(em));
        check("switching", 128'(switching), 128'(es));
        check("mode_done", 128'(mode_done), 128'(ed));
        check("lb_count", 128'(lb_count), 128'(el));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk_in);
        @(negedge clk_in);
        if (chk_en) compare_all();
    endtask

    task automatic set_mode(int lane, logic [1:0] m);
        if (m_mode[lane] == int'(m) && !m_guard[lane]) return;
        mode_wr[lane] = 1'b1;
        mode_in[2*lane +: 2] = m;
        step();
        mode_wr[lane] = 1'b0;
        for (int k = 0; k < G + 4 && m_guard[lane]; k++) step();
        check("set_mode_settled", 128'(cur_mode[2*lane +: 2]), 128'(m));
    endtask

    initial begin
        int sw, done, idle;
        logic [W-1:0] prev_ic0, prev_ic1;

        reset = 1'b1;
        data_in_chan = '0; data_in_xcvr = '0;
        mode_wr = '0; mode_in = '0; lb_count_clr = '0;
        for (int l = 0; l < NL; l++) begin
            m_mode[l] = 0; m_target[l] = 0; m_gend[l] = 0; m_guard[l] = 0;
            m_done[l] = 0; m_lb[l] = 0; m_oc[l] = IDLE; m_ox[l] = IDLE;
        end

        // T1: reset state
        data_in_chan = {rand_word(), rand_word()};
        data_in_xcvr = {rand_word(), rand_word()};
        repeat (3) step();
        check("t1_out_chan", 128'(data_out_chan), 128'(0));
        check("t1_out_xcvr", 128'(data_out_xcvr), 128'(0));
        check("t1_cur_mode", 128'(cur_mode), 128'(0));
        check("t1_switching", 128'(switching), 128'(0));
        check("t1_lb_count", 128'(lb_count), 128'(0));
        reset = 1'b0;

        // T2: routing table on lane 0
        tbl[0] = '{2'd0, 40'h12_3456_789A, 40'hAB_CDEF_0123, 40'hAB_CDEF_0123, 40'h12_3456_789A};
        tbl[1] = '{2'd1, 40'h55_5555_5555, 40'hAA_AAAA_AAAA, 40'h55_5555_5555, 40'h00_0000_0000};
        tbl[2] = '{2'd2, 40'h01_0203_0405, 40'hF0_E0D0_C0B0, 40'h00_0000_0000, 40'hF0_E0D0_C0B0};
        tbl[3] = '{2'd3, 40'hDE_ADBE_EF01, 40'hCA_FEBA_BE02, 40'h00_0000_0000, 40'h00_0000_0000};
        tbl[4] = '{2'd0, 40'hFF_FFFF_FFFF, 40'h00_0000_0001, 40'h00_0000_0001, 40'hFF_FFFF_FFFF};
        tbl[5] = '{2'd2, 40'h80_0000_0000, 40'hFF_FFFF_FFFF, 40'h00_0000_0000, 40'hFF_FFFF_FFFF};
        for (int i = 0; i < 6; i++) begin
            set_mode(0, tbl[i].mode);
            data_in_chan[W-1:0] = tbl[i].ic;
            data_in_xcvr[W-1:0] = tbl[i].ix;
            data_in_chan[W +: W] = rand_word();
            data_in_xcvr[W +: W] = rand_word();
            step();
            check("tbl_out_chan", 128'(data_out_chan[W-1:0]), 128'(tbl[i].ec));
            check("tbl_out_xcvr", 128'(data_out_xcvr[W-1:0]), 128'(tbl[i].ex));
        end

        // T3: lane 1 to NEAR_LB, lane 0 stays NORMAL
        set_mode(0, 2'd0);
        set_mode(1, 2'd0);
        sw = 0; done = 0; idle = 0;
        prev_ic0 = '0; prev_ic1 = '0;
        for (int k = 0; k < 9; k++) begin
            mode_wr[1] = (k == 0);
            mode_in[3:2] = 2'd1;
            data_in_chan = {rand_word(), rand_word()};
            data_in_xcvr = {rand_word(), rand_word()};
            prev_ic0 = data_in_chan[W-1:0];
            prev_ic1 = data_in_chan[W +: W];
            step();
            sw   += int'(switching[1]);
            done += int'(mode_done[1]);
            if (data_out_chan[W +: W] == IDLE) idle++;
            check("t3_lane0_pass", 128'(data_out_xcvr[W-1:0]), 128'(prev_ic0));
        end
        mode_wr = '0;
        check("t3_switch_cycles", 128'(sw), 128'(G));
        check("t3_done_pulses", 128'(done), 128'(1));
        check("t3_idle_words", 128'(idle), 128'(G));
        check("t3_near_chan", 128'(data_out_chan[W +: W]), 128'(prev_ic1));
        check("t3_near_xcvr", 128'(data_out_xcvr[W +: W]), 128'(IDLE));

        // T4: lane 0 re-request two cycles into the guard
        sw = 0; done = 0;
        for (int k = 0; k < 12; k++) begin
            mode_wr[0] = (k == 0 || k == 2);
            mode_in[1:0] = (k == 0) ? 2'd2 : 2'd3;
            data_in_chan = {rand_word(), rand_word()};
            data_in_xcvr = {rand_word(), rand_word()};
            step();
            sw   += int'(switching[0]);
            done += int'(mode_done[0]);
        end
        mode_wr = '0;
        check("t4_switch_cycles", 128'(sw), 128'(6));
        check("t4_done_pulses", 128'(done), 128'(1));
        check("t4_cur_mode", 128'(cur_mode[1:0]), 128'(3));

        // T5: counter saturation and clear priority
        set_mode(0, 2'd1);
        chk_en = 1'b0;
        repeat (65540) step();
        chk_en = 1'b1;
        step();
        check("t5_saturated", 128'(lb_count[15:0]), 128'(16'hFFFF));
        lb_count_clr[0] = 1'b1;
        step();
        check("t5_clear", 128'(lb_count[15:0]), 128'(0));
        lb_count_clr[0] = 1'b0;
        step();
        check("t5_after_clear", 128'(lb_count[15:0]), 128'(1));

        // T6: reset in the middle of a guard
        mode_wr[0] = 1'b1; mode_in[1:0] = 2'd2;
        step();
        mode_wr[0] = 1'b0;
        step();
        check("t6_in_guard", 128'(switching[0]), 128'(1));
        reset = 1'b1;
        step();
        check("t6_switching", 128'(switching), 128'(0));
        check("t6_cur_mode", 128'(cur_mode), 128'(0));
        check("t6_mode_done", 128'(mode_done), 128'(0));
        check("t6_out_chan", 128'(data_out_chan), 128'(0));
        check("t6_out_xcvr", 128'(data_out_xcvr), 128'(0));
        reset = 1'b0;
        done = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            done += int'(mode_done[0]);
        end
        check("t6_no_late_done", 128'(done), 128'(0));

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            for (int l = 0; l < NL; l++) begin
                mode_wr[l]      = ($urandom_range(0, 7) == 0);
                mode_in[2*l +: 2] = 2'($urandom_range(0, 3));
                lb_count_clr[l] = ($urandom_range(0, 31) == 0);
            end
            reset = ($urandom_range(0, 499) == 0);
            data_in_chan = {rand_word(), rand_word()};
            data_in_xcvr = {rand_word(), rand_word()};
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
